// File: rtl/batt_mon.sv
// Battery monitor: 8-sample boxcar average with debounced low-battery flag and hysteresis recovery.
// Define BATT_MON_LATCH_EN to make the LOW state terminal (batt_low held until rst).
module batt_mon #(
  parameter logic [11:0] LOW_THRESH = 12'h800,
  parameter logic [11:0] HYST       = 12'h040,
  parameter int          PERSIST    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] batt,
  input  logic        batt_vld,
  output logic [11:0] batt_avg,
  output logic        avg_vld,
  output logic        batt_low
);

  typedef enum logic [1:0] {FILL, OK, LOW} state_t;

  logic [11:0] samples [8];
  logic [2:0]  wptr;
  logic [14:0] sum;
  logic        vld_d1;
  logic        vld_d2;
  logic [2:0]  fill_cnt;
  logic [3:0]  pcnt;
  state_t      state;

  localparam logic [3:0] PERSIST_CNT = 4'(PERSIST);

  // Circular buffer and running sum; unwritten entries hold 0 so the fill needs no special case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) samples[i] <= '0;
      wptr     <= '0;
      sum      <= '0;
      vld_d1   <= 1'b0;
      vld_d2   <= 1'b0;
      batt_avg <= '0;
    end else begin
      vld_d1 <= batt_vld;
      vld_d2 <= vld_d1;
      if (batt_vld) begin
        samples[wptr] <= batt;
        wptr          <= wptr + 3'd1;
        sum           <= sum + 15'(batt) - 15'(samples[wptr]);
      end
      if (vld_d1) batt_avg <= sum[14:3];
    end
  end

`ifndef BATT_MON_LATCH_EN
  localparam logic [12:0] REC_SUM   = 13'(LOW_THRESH) + 13'(HYST);
  localparam logic [11:0] REC_THRESH = REC_SUM[12] ? 12'hFFF : REC_SUM[11:0];
`endif

  // vld_d2 marks the cycle in which batt_avg holds a fresh average, so each is judged once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      fill_cnt <= '0;
      pcnt     <= '0;
      avg_vld  <= 1'b0;
      batt_low <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (vld_d1) begin
            if (fill_cnt == 3'd7) begin
              state   <= OK;
              avg_vld <= 1'b1;
            end else begin
              fill_cnt <= fill_cnt + 3'd1;
            end
          end
        end
        OK: begin
          if (vld_d2) begin
            if (batt_avg < LOW_THRESH) begin
              if (pcnt + 4'd1 == PERSIST_CNT) begin
                state    <= LOW;
                batt_low <= 1'b1;
                pcnt     <= '0;
              end else begin
                pcnt <= pcnt + 4'd1;
              end
            end else begin
              pcnt <= '0;
            end
          end
        end
        LOW: begin
`ifndef BATT_MON_LATCH_EN
          if (vld_d2) begin
            if (batt_avg >= REC_THRESH) begin
              if (pcnt + 4'd1 == PERSIST_CNT) begin
                state    <= OK;
                batt_low <= 1'b0;
                pcnt     <= '0;
              end else begin
                pcnt <= pcnt + 4'd1;
              end
            end else begin
              pcnt <= '0;
            end
          end
`else
          state <= LOW;
`endif
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_batt_mon.sv
// Directed self-checking bench for batt_mon (default and saturated-threshold instances).
module tb_batt_mon;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] batt;
  logic        vld1, vld2;
  logic [11:0] avg1, avg2;
  logic        avld1, avld2, low1, low2;
  int          checks = 0;
  int          failures = 0;

`ifdef BATT_MON_LATCH_EN
  localparam logic RECOVERED = 1'b1;
`else
  localparam logic RECOVERED = 1'b0;
`endif

  always #5 clk = ~clk;

  batt_mon dut (
    .clk(clk), .rst(rst), .batt(batt), .batt_vld(vld1),
    .batt_avg(avg1), .avg_vld(avld1), .batt_low(low1)
  );

  batt_mon #(.LOW_THRESH(12'hFF0), .HYST(12'h040), .PERSIST(4)) dut_sat (
    .clk(clk), .rst(rst), .batt(batt), .batt_vld(vld2),
    .batt_avg(avg2), .avg_vld(avld2), .batt_low(low2)
  );

  // One isolated strobe per iteration, then let the pipeline and FSM settle.
  task automatic strobe(input logic [11:0] v, input int n, input bit sel);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      batt = v;
      if (sel) vld2 = 1'b1; else vld1 = 1'b1;
      @(negedge clk);
      vld1 = 1'b0;
      vld2 = 1'b0;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; batt = '0; vld1 = 1'b0; vld2 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (avg1 !== 12'h000) begin failures++; $display("FAIL reset_avg got=%h exp=000", avg1); end
    checks++; if (avld1 !== 1'b0) begin failures++; $display("FAIL reset_avg_vld got=%b exp=0", avld1); end
    checks++; if (low1 !== 1'b0) begin failures++; $display("FAIL reset_low got=%b exp=0", low1); end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    strobe(12'h900, 7, 1'b0);
    @(negedge clk); batt = 12'h900; vld1 = 1'b1;
    @(negedge clk); vld1 = 1'b0;
    checks++; if (avld1 !== 1'b0) begin failures++; $display("FAIL fill_vld_early got=%b exp=0", avld1); end
    @(negedge clk);
    checks++; if (avld1 !== 1'b1) begin failures++; $display("FAIL fill_vld_rise got=%b exp=1", avld1); end
    checks++; if (avg1 !== 12'h900) begin failures++; $display("FAIL fill_avg got=%h exp=900", avg1); end
    checks++; if (low1 !== 1'b0) begin failures++; $display("FAIL fill_low got=%b exp=0", low1); end
    repeat (2) @(negedge clk);
  endtask

  // Averages step 8C0,880,840,800,7C0,780,740,700: the 4th below 800 is the 8th strobe.
  task automatic test_entry();
    for (int k = 0; k < 8; k++) begin
      strobe(12'h700, 1, 1'b0);
      checks++;
      if (low1 !== (k == 7)) begin
        failures++; $display("FAIL entry_low[%0d] got=%b exp=%b", k, low1, (k == 7));
      end
    end
    checks++; if (avg1 !== 12'h700) begin failures++; $display("FAIL entry_avg got=%h exp=700", avg1); end
  endtask

  // 3 low averages, one exactly 800 (sum 4000), 3 low, then a 4th low enters LOW.
  task automatic test_interrupted();
    do_reset();
    strobe(12'h7F0, 10, 1'b0);
    strobe(12'h870, 1, 1'b0);
    checks++; if (avg1 !== 12'h800) begin failures++; $display("FAIL intr_avg got=%h exp=800", avg1); end
    strobe(12'h700, 3, 1'b0);
    checks++; if (low1 !== 1'b0) begin failures++; $display("FAIL intr_low got=%b exp=0", low1); end
    strobe(12'h700, 1, 1'b0);
    checks++; if (low1 !== 1'b1) begin failures++; $display("FAIL intr_enter got=%b exp=1", low1); end
  endtask

  // Window only reaches an average of 840 on the 8th strobe, so recovery needs 11.
  task automatic test_hysteresis();
    strobe(12'h820, 12, 1'b0);
    checks++; if (low1 !== 1'b1) begin failures++; $display("FAIL hyst_820 got=%b exp=1", low1); end
    strobe(12'h840, 10, 1'b0);
    checks++; if (low1 !== 1'b1) begin failures++; $display("FAIL hyst_840x3 got=%b exp=1", low1); end
    strobe(12'h840, 1, 1'b0);
    checks++; if (low1 !== RECOVERED) begin failures++; $display("FAIL hyst_840x4 got=%b exp=%b", low1, RECOVERED); end
  endtask

  task automatic test_reset_mid();
    strobe(12'h700, 5, 1'b0);
    checks++; if (low1 !== 1'b1) begin failures++; $display("FAIL mid_pre_low got=%b exp=1", low1); end
    strobe(12'h840, 9, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (avg1 !== 12'h000) begin failures++; $display("FAIL mid_avg got=%h exp=000", avg1); end
    checks++; if (avld1 !== 1'b0) begin failures++; $display("FAIL mid_avg_vld got=%b exp=0", avld1); end
    checks++; if (low1 !== 1'b0) begin failures++; $display("FAIL mid_low got=%b exp=0", low1); end
    #2;
    rst = 1'b0;
    strobe(12'h100, 7, 1'b0);
    checks++; if (avld1 !== 1'b0) begin failures++; $display("FAIL mid_refill_vld got=%b exp=0", avld1); end
    checks++; if (avg1 !== 12'h0E0) begin failures++; $display("FAIL mid_refill_avg got=%h exp=0e0", avg1); end
    strobe(12'h100, 1, 1'b0);
    checks++; if (avld1 !== 1'b1) begin failures++; $display("FAIL mid_refill_done got=%b exp=1", avld1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      batt = 12'(i);
      vld1 = 1'b1;
    end
    @(negedge clk);
    vld1 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (avg1 !== 12'd15) begin failures++; $display("FAIL b2b_avg got=%0d exp=15", avg1); end
    checks++; if (avld1 !== 1'b1) begin failures++; $display("FAIL b2b_vld got=%b exp=1", avld1); end
    checks++; if (low1 !== 1'b1) begin failures++; $display("FAIL b2b_low got=%b exp=1", low1); end
  endtask

  // Threshold FF0+040 saturates to FFF, reachable only with a window full of FFF.
  task automatic test_saturation();
    do_reset();
    strobe(12'h100, 11, 1'b1);
    checks++; if (low2 !== 1'b1) begin failures++; $display("FAIL sat_enter got=%b exp=1", low2); end
    strobe(12'hFFE, 8, 1'b1);
    checks++; if (low2 !== 1'b1) begin failures++; $display("FAIL sat_ffe got=%b exp=1", low2); end
    strobe(12'hFFF, 10, 1'b1);
    checks++; if (low2 !== 1'b1) begin failures++; $display("FAIL sat_fff_x3 got=%b exp=1", low2); end
    strobe(12'hFFF, 1, 1'b1);
    checks++; if (low2 !== RECOVERED) begin failures++; $display("FAIL sat_fff_x4 got=%b exp=%b", low2, RECOVERED); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_entry();
    test_interrupted();
    test_hysteresis();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
